seg_scan_ctrl: RTL



---
 rtl/seg_scan_pkg.sv | 33 +++
 rtl/seg_scan_ctrl_hex_decode.sv | 17 +
 rtl/seg_scan_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and hex-to-segment lookup for the multiplexed 7-segment display blocks.
package seg_scan_pkg;

  typedef logic [7:0] seg_t;

  // Active-high view of a fully dark digit; drivers apply output polarity.
  localparam seg_t SEG_OFF = 8'h00;

  // Lit pattern for one hex nibble, bits ordered a..g, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational nibble + decimal point to segment byte {a..g, dp}, with selectable polarity.
module seg_hex_decode
  import seg_scan_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  seg_t lit;

  assign lit = {hex_to_seg(nibble), dp};
  assign seg = ACTIVE_LOW ? ~lit : lit;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed NUM_DIGITS hex scanner with frame-synchronous shadow latch and anti-ghost blanking.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading zero digits at each shadow load.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output seg_t                    seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        which,
  output logic                    frame_done
);

  localparam int                    PS_W      = $clog2(DIV);
  localparam seg_t                  SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PS_W-1:0]         prescaler;
  logic                    tick;
  logic                    last_digit;
  logic                    pre_load;
  logic                    slot_open;
  logic                    sel;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS-1:0]   en_next;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  seg_t                    dec_seg;

  assign tick       = (prescaler == PS_W'(DIV - 1));
  assign last_digit = (which == IDX_W'(NUM_DIGITS - 1));
  // which is stable across a slot, so one cycle before the wrap tick predicts the shadow load.
  assign pre_load   = (prescaler == PS_W'(DIV - 2)) && last_digit;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      prescaler  <= '0;
      which      <= '0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= pre_load;
      if (tick) which <= last_digit ? '0 : which + 1'b1;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;

  always_comb begin
    logic run;
    // NOTE: defaults first so every path assigns and no latch is inferred.
    run     = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run        = run && (data[4*i +: 4] == 4'h0) && !dp[i];
      lz_mask[i] = run;
    end
  end

  assign en_next = digit_en & ~lz_mask;
`else
  assign en_next = digit_en;
`endif

  // Whole-frame snapshot: inputs are only observed at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
    end else if (tick && last_digit) begin
      sh_data <= data;
      sh_dp   <= dp;
      sh_en   <= en_next;
    end
  end

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign slot_open = 1'b1;
    end else begin : g_blank
      assign slot_open = (prescaler >= PS_W'(BLANK_CYC));
    end
  endgenerate

  assign sel    = slot_open && sh_en[which];
  assign onehot = NUM_DIGITS'(1) << which;
  assign an_sel = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;

  seg_hex_decode #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW != 0)
  ) u_dec (
    .nibble(sh_data[{which, 2'b00} +: 4]),
    .dp    (sh_dp[which]),
    .seg   (dec_seg)
  );

  // Registered pins: one-hot select and pattern change together on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else if (sel) begin
      seg <= dec_seg;
      an  <= an_sel;
    end else begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end
  end

endmodule
